// File: rtl/pipes_pkg.sv
// Shared pipeline types: the writeback request carried from the MDU to the
// register-file write port, and the hard-wired zero register index.
package pipes_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wb_req_t;

  function automatic logic [31:0] reg_onehot(input logic [4:0] r);
    return 32'd1 << r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests, DEPTH a power of two >= 2.
// Control state resets asynchronously; the storage array is data and is not reset.
module wb_fifo
  import pipes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  wb_req_t                push_data,
  input  logic                   pop,
  output wb_req_t                head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t         mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, MDU results
// queue and drain on idle cycles; tracks pending MDU writes per register.
// Optional macro WB_MDU_BYPASS_EN: an MDU result may write straight through
// when the queue is empty and the pipeline is not writing.
module wb_arbiter
  import pipes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wb_reg_write,
  input  logic [4:0]             wb_wa,
  input  logic [31:0]            wb_wd,
  input  logic                   mdu_valid,
  input  logic [4:0]             mdu_wa,
  input  logic [31:0]            mdu_wd,
  output logic                   mdu_ready,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_rd,
  output logic [31:0]            busy,
  output logic                   rf_wen,
  output logic [4:0]             rf_wa,
  output logic [31:0]            rf_wd,
  output logic [$clog2(DEPTH):0] fifo_count
);

  wb_req_t     mdu_req;
  wb_req_t     head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pipe_wr;
  logic        accept;
  logic        bypass;
  logic        push;
  logic        pop;
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  assign mdu_req   = '{wa: mdu_wa, wd: mdu_wd};
  assign mdu_ready = !fifo_full;

  always_comb begin
    pipe_wr = wb_reg_write && (wb_wa != REG_ZERO);
    accept  = mdu_valid && mdu_ready;
`ifdef WB_MDU_BYPASS_EN
    bypass  = accept && (mdu_wa != REG_ZERO) && fifo_empty && !pipe_wr;
`else
    bypass  = 1'b0;
`endif
    // Results addressed to $0 are accepted but never stored.
    push    = accept && (mdu_wa != REG_ZERO) && !bypass;
    pop     = !pipe_wr && !fifo_empty;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (mdu_req),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    rf_wen = 1'b0;
    rf_wa  = REG_ZERO;
    rf_wd  = '0;
    if (resetn) begin
      if (pipe_wr) begin
        rf_wen = 1'b1;
        rf_wa  = wb_wa;
        rf_wd  = wb_wd;
      end else if (!fifo_empty) begin
        rf_wen = 1'b1;
        rf_wa  = head.wa;
        rf_wd  = head.wd;
      end else if (bypass) begin
        rf_wen = 1'b1;
        rf_wa  = mdu_wa;
        rf_wd  = mdu_wd;
      end
    end
  end

  // A new issue to the same register outranks the retiring write.
  always_comb begin
    set_vec = (issue_valid && (issue_rd != REG_ZERO)) ? reg_onehot(issue_rd) : '0;
    clr_vec = (pop || bypass) ? reg_onehot(rf_wa) : '0;
    busy_d  = ((busy_q & ~clr_vec) | set_vec) & ~32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy = busy_q;

  a_no_same_reg: assert property (@(posedge clk) disable iff (!resetn)
    !(wb_reg_write && (wb_wa != REG_ZERO) && !fifo_empty && (wb_wa == head.wa)))
    else $error("wb_arbiter: pipeline write targets the queued MDU destination");

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with DEPTH=2; expectations follow the
// WB_MDU_BYPASS_EN setting of the build.
module tb_wb_arbiter;

  localparam int DEPTH = 2;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic                   wb_reg_write;
  logic [4:0]             wb_wa;
  logic [31:0]            wb_wd;
  logic                   mdu_valid;
  logic [4:0]             mdu_wa;
  logic [31:0]            mdu_wd;
  logic                   mdu_ready;
  logic                   issue_valid;
  logic [4:0]             issue_rd;
  logic [31:0]            busy;
  logic                   rf_wen;
  logic [4:0]             rf_wa;
  logic [31:0]            rf_wd;
  logic [$clog2(DEPTH):0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .wb_reg_write (wb_reg_write),
    .wb_wa        (wb_wa),
    .wb_wd        (wb_wd),
    .mdu_valid    (mdu_valid),
    .mdu_wa       (mdu_wa),
    .mdu_wd       (mdu_wd),
    .mdu_ready    (mdu_ready),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .busy         (busy),
    .rf_wen       (rf_wen),
    .rf_wa        (rf_wa),
    .rf_wd        (rf_wd),
    .fifo_count   (fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wb_reg_write = 1'b0; wb_wa = 5'd0; wb_wd = 32'd0;
    mdu_valid    = 1'b0; mdu_wa = 5'd0; mdu_wd = 32'd0;
    issue_valid  = 1'b0; issue_rd = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic [4:0] wa, input logic [31:0] wd);
    wb_reg_write = 1'b1; wb_wa = wa; wb_wd = wd;
  endtask

  task automatic mdu(input logic [4:0] wa, input logic [31:0] wd);
    mdu_valid = 1'b1; mdu_wa = wa; mdu_wd = wd;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1; issue_rd = rd;
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    #3;
    check("rst_wen", rf_wen, 0);
    check("rst_wa", rf_wa, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    @(negedge clk);
    check("rst_ready", mdu_ready, 1);

    // Pipeline only
    tick(); idle(); pipe(5'd5, 32'h1234);
    @(negedge clk);
    check("pipe_wen", rf_wen, 1);
    check("pipe_wa", rf_wa, 5);
    check("pipe_wd", rf_wd, 32'h1234);
    tick(); idle();
    @(negedge clk);
    check("pipe_count", fifo_count, 0);
    check("pipe_idle_wen", rf_wen, 0);

    // Collision: pipeline $3 alongside MDU result for $8
    tick(); idle(); issue(5'd8);
    tick(); idle(); mdu(5'd8, 32'hCAFE); pipe(5'd3, 32'h33);
    @(negedge clk);
    check("col_wa_pipe", rf_wa, 3);
    check("col_wd_pipe", rf_wd, 32'h33);
    check("col_busy_set", busy, 32'h100);
    tick(); idle();
    @(negedge clk);
    check("col_wen_mdu", rf_wen, 1);
    check("col_wa_mdu", rf_wa, 8);
    check("col_wd_mdu", rf_wd, 32'hCAFE);
    check("col_count", fifo_count, 1);
    check("col_busy_held", busy, 32'h100);
    tick(); idle();
    @(negedge clk);
    check("col_busy_clr", busy, 0);
    check("col_count_drain", fifo_count, 0);
    check("col_wen_idle", rf_wen, 0);

    // Backpressure: pipeline busy every cycle, three results for DEPTH=2
    tick(); idle(); pipe(5'd1, 32'h11); mdu(5'd10, 32'hA1);
    @(negedge clk);
    check("bp_ready0", mdu_ready, 1);
    tick(); idle(); pipe(5'd1, 32'h11); mdu(5'd11, 32'hA2);
    @(negedge clk);
    check("bp_ready1", mdu_ready, 1);
    check("bp_count1", fifo_count, 1);
    tick(); idle(); pipe(5'd1, 32'h11); mdu(5'd12, 32'hA3);
    @(negedge clk);
    check("bp_ready_full", mdu_ready, 0);
    check("bp_count_full", fifo_count, 2);
    tick();
    @(negedge clk);
    check("bp_held_ready", mdu_ready, 0);
    check("bp_pipe_wins", rf_wa, 1);
    tick(); wb_reg_write = 1'b0; wb_wa = 5'd0;
    @(negedge clk);
    check("bp_drain1_wa", rf_wa, 10);
    check("bp_drain1_wd", rf_wd, 32'hA1);
    check("bp_drain1_ready", mdu_ready, 0);
    tick();
    @(negedge clk);
    check("bp_drain2_wa", rf_wa, 11);
    check("bp_drain2_wd", rf_wd, 32'hA2);
    check("bp_drain2_ready", mdu_ready, 1);
    check("bp_drain2_count", fifo_count, 1);
    tick(); idle();
    @(negedge clk);
    check("bp_drain3_wa", rf_wa, 12);
    check("bp_drain3_wd", rf_wd, 32'hA3);
    check("bp_pushpop_count", fifo_count, 1);
    tick();
    @(negedge clk);
    check("bp_empty_count", fifo_count, 0);
    check("bp_empty_wen", rf_wen, 0);

    // Register $0
    tick(); idle(); mdu(5'd0, 32'hDEAD); issue(5'd0);
    @(negedge clk);
    check("r0_ready", mdu_ready, 1);
    check("r0_wen", rf_wen, 0);
    tick(); idle();
    @(negedge clk);
    check("r0_count", fifo_count, 0);
    check("r0_busy", busy, 0);
    check("r0_wen_after", rf_wen, 0);
    tick(); idle(); mdu(5'd7, 32'h77); pipe(5'd2, 32'h22);
    @(negedge clk);
    check("r0_queue_pipe", rf_wa, 2);
    tick(); idle(); pipe(5'd0, 32'hFFFF);
    @(negedge clk);
    check("r0_pipe0_wen", rf_wen, 1);
    check("r0_pipe0_wa", rf_wa, 7);
    check("r0_pipe0_wd", rf_wd, 32'h77);
    tick(); idle();
    @(negedge clk);
    check("r0_drained", fifo_count, 0);

    // Reset mid-operation
    tick(); idle(); issue(5'd8);
    tick(); idle(); issue(5'd9); mdu(5'd8, 32'h1); pipe(5'd1, 32'h44);
    tick(); idle(); mdu(5'd9, 32'h2); pipe(5'd1, 32'h44);
    tick(); idle(); pipe(5'd1, 32'h44);
    @(negedge clk);
    check("mr_count_pre", fifo_count, 2);
    check("mr_busy_pre", busy, 32'h300);
    check("mr_wen_pre", rf_wen, 1);
    #1 resetn = 1'b0;
    #1;
    check("mr_wen", rf_wen, 0);
    check("mr_wa", rf_wa, 0);
    check("mr_wd", rf_wd, 0);
    check("mr_busy", busy, 0);
    check("mr_count", fifo_count, 0);
    #1 resetn = 1'b1;
    tick(); idle();
    @(negedge clk);
    check("mr_count_post", fifo_count, 0);
    check("mr_wen_post", rf_wen, 0);
    check("mr_ready_post", mdu_ready, 1);

    // Empty FIFO, idle pipeline: bypass or one-cycle queue
    tick(); idle(); issue(5'd4);
    tick(); idle(); mdu(5'd4, 32'h55);
    @(negedge clk);
    check("bypass_busy_set", busy, 32'h10);
`ifdef WB_MDU_BYPASS_EN
    check("bypass_wen", rf_wen, 1);
    check("bypass_wa", rf_wa, 4);
    check("bypass_wd", rf_wd, 32'h55);
    tick(); idle();
    @(negedge clk);
    check("bypass_count", fifo_count, 0);
    check("bypass_busy_clr", busy, 0);
    check("bypass_wen_after", rf_wen, 0);
`else
    check("queued_wen0", rf_wen, 0);
    tick(); idle();
    @(negedge clk);
    check("queued_wen1", rf_wen, 1);
    check("queued_wa", rf_wa, 4);
    check("queued_wd", rf_wd, 32'h55);
    check("queued_count", fifo_count, 1);
    check("queued_busy_held", busy, 32'h10);
`endif
    tick(); idle();
    @(negedge clk);
    check("late_count", fifo_count, 0);
    check("late_busy", busy, 0);
    check("late_wen", rf_wen, 0);

    // Re-issue to a register in the same cycle its queued write retires
    tick(); idle(); issue(5'd6);
    tick(); idle(); mdu(5'd6, 32'h66); pipe(5'd1, 32'h11);
    tick(); idle(); issue(5'd6);
    @(negedge clk);
    check("sw_pop_wa", rf_wa, 6);
    check("sw_pop_wd", rf_wd, 32'h66);
    tick(); idle();
    @(negedge clk);
    check("sw_busy_kept", busy, 32'h40);
    check("sw_count", fifo_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Owns the single register-file write port.
- Shares it between the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU).
- The pipeline always wins the port. MDU results are queued in a small FIFO and drain on idle writeback cycles.
- Keeps a per-register pending-write scoreboard, which decode uses to stall on RAW/WAW hazards against outstanding MDU results.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock; all state on rising edge
- resetn  in  1  asynchronous active-low reset
- wb_reg_write  in  1  pipeline writeback write enable
- wb_wa  in  5  pipeline destination register
- wb_wd  in  32  pipeline write data (mem_to_reg mux output)
- mdu_valid  in  1  MDU result valid
- mdu_wa  in  5  MDU destination register
- mdu_wd  in  32  MDU result data
- mdu_ready  out  1  FIFO can accept a result
- issue_valid  in  1  decode issues an MDU op this cycle
- issue_rd  in  5  destination of the issued MDU op
- busy  out  32  bit r set = register r has an MDU write pending
- rf_wen  out  1  regfile write enable
- rf_wa  out  5  regfile write address
- rf_wd  out  32  regfile write data
- fifo_count  out  $clog2(DEPTH)+1  occupancy, for debug

Behaviour:
- Reset (resetn low, asynchronous):
  - FIFO empty, rd/wr pointers 0, fifo_count=0, busy=0.
  - rf_wen forced 0 while resetn low; rf_wa=0, rf_wd=0.
  - mdu_ready=1 once resetn is released.
- MDU handshake:
  - Transfer when mdu_valid && mdu_ready.
  - mdu_ready = (fifo_count != DEPTH), combinational from state only, never from mdu_valid.
  - An accepted entry is enqueued at the clock edge.
  - mdu_valid with mdu_ready=0: no transfer; MDU holds its data stable.
- Port selection (combinational, same cycle):
  - Pipeline path: wb_reg_write && wb_wa!=0 gives rf_wen=1, rf_wa=wb_wa, rf_wd=wb_wd. The FIFO does not pop.
  - FIFO path: otherwise, if the FIFO is non-empty, rf_wen=1 with the head entry, and the head pops at the edge.
  - Idle: rf_wen=0, rf_wa=0, rf_wd=0.
- Register $0:
  - Pipeline writes to $0 are dropped and do not block the port that cycle.
  - MDU results to $0 are accepted and dropped (not enqueued).
- Latency (macro off): an MDU result is written no earlier than 1 cycle after acceptance. Starvation is bounded only by the pipeline's idle cycles.
- Simultaneous push and pop:
  - Allowed when full: pop frees a slot, but mdu_ready is still 0 that cycle because it is state-based.
  - Count unchanged when push and pop coincide; pointers wrap modulo DEPTH.
- Scoreboard:
  - Issue sets busy[issue_rd] at the edge when issue_valid && issue_rd!=0.
  - A FIFO pop, or a bypass write when the macro is on, clears busy[rf_wa] at the edge.
  - Set and clear of the same bit in the same cycle: set wins.
  - busy[0] is always 0.
- Ordering invariant:
  - Decode stalls any instruction whose sources or destination hit busy, so the pipeline and FIFO head never target the same register in one cycle.
  - Simulation assertion: error if wb_reg_write && wb_wa==head.wa && FIFO non-empty && wb_wa!=0.
- Reset mid-operation: queued results and busy bits are discarded. The upstream pipeline is flushed by the same reset.

Optional Feature:
- Macro: WB_MDU_BYPASS_EN.
- Defined: when the FIFO is empty and the pipeline is not writing (a $0 write counts as not writing), an accepted MDU result drives the rf_* outputs in the same cycle and is not enqueued. This gives 0-cycle latency; busy clears at that edge.
- Undefined: every MDU result goes through the FIFO, minimum 1 cycle.

Decomposition:
- Shared package pipes gains:
  - typedef wb_req_t {logic [4:0] wa; logic [31:0] wd;}
  - constant REG_ZERO = 5'd0
- Sub-module wb_fifo: a parameterised DEPTH synchronous FIFO of wb_req_t with async active-low reset and push/pop/full/empty/count.
- The scoreboard and selection logic stay in wb_arbiter.

Test Plan:
- Pipeline only: wb_reg_write=1, wb_wa=5, wb_wd=0x1234 → same cycle rf_wen=1, rf_wa=5, rf_wd=0x1234. FIFO untouched.
- Collision:
  - Stimulus: issue rd=8, then mdu_valid with wa=8, wd=0xCAFE in the same cycle as a pipeline write to $3.
  - Response: $3 written first; next idle cycle rf_wa=8, rf_wd=0xCAFE; busy[8] clears the following edge.
- Backpressure:
  - Stimulus: pipeline writes every cycle, three MDU results with DEPTH=2.
  - Response: mdu_ready drops after 2 accepts; the third is held. Once the pipeline idles, the three drain in order 1,2,3.
- Register $0: MDU result with wa=0 → accepted, never written, fifo_count stays 0. A pipeline write to $0 plus a queued entry → the queued entry is written that cycle.
- Reset mid-operation: 2 entries queued, busy=0x00000300, resetn pulsed low asynchronously between edges → busy=0, fifo_count=0, rf_wen=0 immediately.
- WB_MDU_BYPASS_EN defined: empty FIFO, no pipeline write, MDU wa=4, wd=0x55 → rf_wen=1 in the same cycle, fifo_count stays 0. Undefined → written 1 cycle later.
